// File: rtl/clk_div_select.sv
// Push-button front end: synchronises and debounces up/down buttons and steps a saturating divide setting.
// Optional auto-repeat while a button is held: define CLK_DIV_SELECT_AUTO_REPEAT_EN.
module clk_div_select #(
  parameter int DIV_W           = 4,
  parameter int DIV_RESET       = 3,
  parameter int DIV_MIN         = 1,
  parameter int DIV_MAX         = 15,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  output logic [DIV_W-1:0] div_o,
  output logic             div_upd_o,
  output logic             btn_busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST_C  = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] DIV_MIN_C  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_MAX_C  = DIV_W'(DIV_MAX);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 || DIV_MIN > DIV_RESET ||
      DIV_RESET > DIV_MAX || DIV_MAX > (2 ** DIV_W) - 1) begin : g_bad_params
    $error("clk_div_select: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             upd_q, upd_d;
  logic             up_meta_q, up_sync_q, dn_meta_q, dn_sync_q;
  logic             up_s, dn_s, lat_s, oth_s, step_s;

`ifdef CLK_DIV_SELECT_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rcnt_q, rcnt_d;
`endif

  // Two-flop synchronisers for the raw buttons
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      up_meta_q <= 1'b0;
      up_sync_q <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_sync_q <= 1'b0;
    end else begin
      up_meta_q <= btn_up_i;
      up_sync_q <= up_meta_q;
      dn_meta_q <= btn_dn_i;
      dn_sync_q <= dn_meta_q;
    end
  end

  assign up_s  = up_sync_q;
  assign dn_s  = dn_sync_q;
  assign lat_s = dir_q ? up_s : dn_s;
  assign oth_s = dir_q ? dn_s : up_s;

  // State, counters and the divide register
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      div_q   <= DIV_RST_C;
      upd_q   <= 1'b0;
`ifdef CLK_DIV_SELECT_AUTO_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      upd_q   <= upd_d;
`ifdef CLK_DIV_SELECT_AUTO_REPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  // Next-state logic; dir_q=1 means the up button owns the current press
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_s  = 1'b0;
`ifdef CLK_DIV_SELECT_AUTO_REPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (up_s ^ dn_s) begin
          dir_d   = up_s;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          state_d = IDLE;
        end
      end
      DEBOUNCE: begin
        if (lat_s && !oth_s) begin
          if (cnt_q == CNT_LAST) begin
            step_s  = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
`ifdef CLK_DIV_SELECT_AUTO_REPEAT_EN
            rcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!lat_s) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
`ifdef CLK_DIV_SELECT_AUTO_REPEAT_EN
          if (rcnt_q == RPT_LAST) begin
            step_s = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RPT_W'(1);
          end
`else
          state_d = HELD;
`endif
        end
      end
      RELEASE: begin
        if (!up_s && !dn_s) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Saturating step; the pulse is raised only when the value really moves
  always_comb begin
    div_d = div_q;
    upd_d = 1'b0;
    if (step_s) begin
      if (dir_q) begin
        if (div_q < DIV_MAX_C) begin
          div_d = div_q + DIV_W'(1);
          upd_d = 1'b1;
        end else begin
          div_d = div_q;
        end
      end else begin
        if (div_q > DIV_MIN_C) begin
          div_d = div_q - DIV_W'(1);
          upd_d = 1'b1;
        end else begin
          div_d = div_q;
        end
      end
    end else begin
      upd_d = 1'b0;
    end
  end

  assign div_o      = div_q;
  assign div_upd_o  = upd_q;
  assign btn_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_select.sv
// Self-checking bench for clk_div_select: table of button presses plus hand-written corner sequences,
// with a scoreboard queue of expected divide values popped on every div_upd_o pulse.
module tb_clk_div_select;

  logic       clk_i     = 1'b0;
  logic       rst       = 1'b1;
  logic       btn_up_i  = 1'b0;
  logic       btn_dn_i  = 1'b0;
  logic [3:0] div_o;
  logic       div_upd_o;
  logic       btn_busy_o;
  bit         clk_run   = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int cur_div = 3;
  logic prev_upd = 1'b0;

  typedef struct {
    logic up;
    logic dn;
    int   hold;
    int   exp_div;
  } vec_t;
  vec_t tab[$];

  clk_div_select dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .btn_up_i   (btn_up_i),
    .btn_dn_i   (btn_dn_i),
    .div_o      (div_o),
    .div_upd_o  (div_upd_o),
    .btn_busy_o (btn_busy_o)
  );

  always begin
    #5;
    if (clk_run) clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every update pulse must match the oldest expected value
  always @(negedge clk_i) begin
    if (div_upd_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected_pulse: got pulse with div_o=%0d, expected no pulse", div_o);
      end else begin
        check("sb_div", div_o, exp_q.pop_front());
      end
      check("upd_two_cycles", prev_upd, 0);
    end
    prev_upd = div_upd_o;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic settle(input string name);
    int c;
    c = 0;
    tick(4);
    while (btn_busy_o && c < 200) begin
      tick(1);
      c++;
    end
    check({name, "_busy"}, btn_busy_o, 0);
    check({name, "_div"}, div_o, cur_div);
    check({name, "_sb_left"}, exp_q.size(), 0);
  endtask

  task automatic press(input logic up, input logic dn, input int hold, input int exp_div, input string name);
    if (exp_div != cur_div) exp_q.push_back(exp_div);
    cur_div  = exp_div;
    btn_up_i = up;
    btn_dn_i = dn;
    tick(hold);
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    settle(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, lat, rel, busy_seen;
    logic pulse_at_step;

    // Expected divide value after each table press, saturating at 1..15
    d = 3;
    for (int i = 0; i < 13; i++) begin
      d = (d < 15) ? d + 1 : d;
      tab.push_back('{1'b1, 1'b0, 30, d});
    end
    for (int i = 0; i < 15; i++) begin
      d = (d > 1) ? d - 1 : d;
      tab.push_back('{1'b0, 1'b1, 30, d});
    end

    // Reset state
    #20;
    rst = 1'b0;
    tick(1);
    check("rst_div", div_o, 3);
    check("rst_upd", div_upd_o, 0);
    check("rst_busy", btn_busy_o, 0);

    // Clean press: edge 1 samples the button, the step lands 18 edges later
    exp_q.push_back(4);
    cur_div = 4;
    btn_up_i = 1'b1;
    lat = -1;
    pulse_at_step = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_i);
      #1;
      if (lat < 0 && div_o == 4'd4) begin
        lat = c;
        pulse_at_step = div_upd_o;
      end
    end
    btn_up_i = 1'b0;
    rel = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_i);
      #1;
      if (rel < 0 && !btn_busy_o) rel = c;
    end
    check("press_latency", lat, 19);
    check("press_pulse", pulse_at_step, 1);
    check("release_latency", rel, 19);
    check("press_div", div_o, 4);
    check("press_sb_left", exp_q.size(), 0);

    // Bouncy button then steady hold: a single increment
    for (int i = 0; i < 12; i++) begin
      btn_up_i = (i % 2 == 0);
      tick(5);
    end
    press(1'b1, 1'b0, 30, 5, "bounce");

    // Async reset with the clock stopped
    @(negedge clk_i);
    clk_run = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_div", div_o, 3);
    check("async_rst_busy", btn_busy_o, 0);
    check("async_rst_upd", div_upd_o, 0);
    #5;
    rst = 1'b0;
    cur_div = 3;
    clk_run = 1'b1;
    tick(2);

    // Table: 13 up presses then 15 down presses, saturating at both ends
    foreach (tab[i]) begin
      press(tab[i].up, tab[i].dn, tab[i].hold, tab[i].exp_div, $sformatf("tab%0d", i));
    end

    // Both buttons together: ignored, FSM never leaves IDLE
    btn_up_i = 1'b1;
    btn_dn_i = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (btn_busy_o) busy_seen = 1;
    end
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    tick(4);
    check("both_busy_seen", busy_seen, 0);
    check("both_div", div_o, cur_div);

    // Down button joins partway through an up debounce: abort, no step
    btn_up_i = 1'b1;
    tick(10);
    btn_dn_i = 1'b1;
    tick(30);
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    settle("abort_dn");

    // Step to 5, then reset in the middle of a debounce
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 30, cur_div + 1, $sformatf("to5_%0d", i));
    check("pre_rst_div", div_o, 5);
    btn_up_i = 1'b1;
    tick(12);
    rst = 1'b1;
    #1;
    check("mid_rst_div", div_o, 3);
    check("mid_rst_upd", div_upd_o, 0);
    check("mid_rst_busy", btn_busy_o, 0);
    cur_div = 3;
    tick(2);
    btn_up_i = 1'b0;
    rst = 1'b0;
    settle("post_rst");

    // Long hold from 3
`ifdef CLK_DIV_SELECT_AUTO_REPEAT_EN
    exp_q.push_back(4);
    exp_q.push_back(5);
    exp_q.push_back(6);
    cur_div = 6;
`else
    exp_q.push_back(4);
    cur_div = 4;
`endif
    btn_up_i = 1'b1;
    tick(200);
    btn_up_i = 1'b0;
    settle("hold200");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_select.md
Name: clk_div_select

Overview:
Operator-facing front end that produces the 4-bit divide setting consumed by clock_divider (its div input).
- Takes two raw push-buttons (up/down).
- Synchronises and debounces them.
- Steps a saturating divide register once per clean press.
- Flags every change with a one-cycle update pulse.
- Runs on the board clock, upstream of the divider.

Parameters:
DIV_W, 4, width of divide setting
DIV_RESET, 3, div_o value after reset
DIV_MIN, 1, lowest allowed div_o
DIV_MAX, 15, highest allowed div_o
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a press or a release
REPEAT_CYCLES, 64, hold period per auto-repeat step (used only with the optional feature)

Ports:
clk_i  input  1  board clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
btn_up_i  input  1  raw, asynchronous, bouncy "increase divide" button
btn_dn_i  input  1  raw, asynchronous, bouncy "decrease divide" button
div_o  output  DIV_W  current divide setting, registered
div_upd_o  output  1  one-cycle pulse, asserted in the same cycle div_o first shows a new value
btn_busy_o  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, immediate):
  - div_o=DIV_RESET, div_upd_o=0, btn_busy_o=0.
  - FSM=IDLE; all counters, synchronisers and the direction flag cleared to 0.
  - Reset mid-operation aborts any press with no step and no pulse.
- Legal parameters: DIV_MIN<=DIV_RESET<=DIV_MAX<=2^DIV_W-1; DEBOUNCE_CYCLES>=2; REPEAT_CYCLES>=2.
- Synchronisers: each button passes through a 2-FF synchroniser; the FSM sees only the synchronised values up_s and dn_s.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - Exactly one of up_s/dn_s high: latch direction, cnt=0, go DEBOUNCE.
  - Both high or both low: stay in IDLE.
- DEBOUNCE:
  - Latched button still high and the other low: cnt++.
  - Latched button low or other button high: return to IDLE with no step.
  - On the edge where cnt==DEBOUNCE_CYCLES-1 with the condition still true: apply step, go HELD.
- HELD:
  - Stay while the latched button is high.
  - When it goes low: cnt=0, go RELEASE.
  - The other button is ignored in this state.
- RELEASE:
  - Both buttons low: cnt++; at cnt==DEBOUNCE_CYCLES-1 go IDLE.
  - Either button high: cnt=0, stay in RELEASE.
- Step rule:
  - Up: if div_o<DIV_MAX then div_o<=div_o+1 and div_upd_o<=1.
  - Down: if div_o>DIV_MIN then div_o<=div_o-1 and div_upd_o<=1.
  - At the limit: div_o unchanged and no pulse.
  - Compare unsigned at DIV_W bits; never wraps.
- div_upd_o returns to 0 on the next edge; it is never high for two consecutive cycles.
- Latency: raw button first sampled high at edge k gives new div_o (with div_upd_o) after edge k+2+DEBOUNCE_CYCLES, i.e. 18 cycles at default.
- Release latency: latched button first sampled low at edge k gives btn_busy_o=0 after edge k+2+DEBOUNCE_CYCLES.
- btn_busy_o is combinational from the state register (state!=IDLE).

Optional Feature:
CLK_DIV_SELECT_AUTO_REPEAT_EN
- Defined:
  - A repeat counter clears on entry to HELD and increments while the latched button stays high.
  - Each time it reaches REPEAT_CYCLES-1: apply another step (same saturation and pulse rules), then clear the counter.
- Not defined:
  - Exactly one step per press.
  - Repeat counter and REPEAT_CYCLES logic absent from RTL.

Test Plan:
1. rst=1 for 20ns then 0 -> div_o=3, div_upd_o=0, btn_busy_o=0. Assert rst while clk_i is stopped -> outputs reset immediately (async).
2. Clean btn_up_i high for 40 cycles then low (defaults) -> div_o 3->4 exactly 18 cycles after the first sampling edge; one div_upd_o pulse; btn_busy_o=0 18 cycles after release.
3. btn_up_i toggling every 5 cycles for 60 cycles, then steady high 30 cycles, then low -> exactly one increment (3->4) and one pulse.
4. 12 clean up presses from 3 -> div_o=15 with 12 pulses; 13th press -> div_o stays 15, no pulse. 14 down presses -> div_o=1, 14 pulses; 15th down press -> no change, no pulse.
5. Both buttons high together for 40 cycles -> no change, btn_busy_o stays 0. btn_dn_i rises at cycle 8 of an up debounce -> abort, no step, div_o unchanged.
6. rst pulsed at cycle 10 of a debounce, after div_o has been stepped to 5 -> div_o=3 immediately, no pulse, FSM IDLE. With CLK_DIV_SELECT_AUTO_REPEAT_EN, REPEAT_CYCLES=64, btn_up_i held 200 cycles from div_o=3 -> steps after cycles 18, 82, 146 -> div_o=6 with 3 pulses.
